// File: rtl/sensor_pkg.sv
// Shared constants, state type and helpers for the seven-sensor voting blocks.
package sensor_pkg;
  localparam int NUM_SENSORS = 7;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    PENDING = 2'd2,
    ALARM   = 2'd3
  } sv_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/sensor_popcount7.sv
// Combinational 7-bit population count, shared by the sensor blocks.
module sensor_popcount7
  import sensor_pkg::*;
(
  input  logic [NUM_SENSORS-1:0] vec,
  output logic [CNT_W-1:0]       cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_SENSORS; i++) cnt = cnt + CNT_W'(vec[i]);
  end
endmodule

// File: rtl/sensor_vote_controller.sv
// Seven-sensor vote controller: sync, prescaled sampling, confirm/alarm/hold-off FSM.
// Optional build macro SENSOR_MASK_EN adds a per-sensor ignore mask input.
module sensor_vote_controller
  import sensor_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int THRESHOLD  = 6,
  parameter int CONFIRM    = 3,
  parameter int HOLDOFF    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_in,
  input  logic                   ack,
`ifdef SENSOR_MASK_EN
  input  logic [NUM_SENSORS-1:0] mask,
`endif
  output logic                   f,
  output logic                   alarm,
  output logic [CNT_W-1:0]       count,
  output logic [1:0]             state_o,
  output logic [7:0]             alarm_total
);
  localparam int PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] THR_L     = CNT_W'(THRESHOLD);
  localparam logic [3:0]       CONFIRM_L = 4'(CONFIRM);
  localparam logic [7:0]       HOLDOFF_L = 8'(HOLDOFF);

  logic [NUM_SENSORS-1:0] s_meta, s, vote_vec;
  logic [PRE_W-1:0]       pre;
  logic [CNT_W-1:0]       pc;
  logic [3:0]             run;
  logic [7:0]             hold_cnt;
  logic                   tick, hit;
  sv_state_t              state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= '0;
      s      <= '0;
    end else begin
      s_meta <= sensor_in;
      s      <= s_meta;
    end
  end

  assign tick = enable && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pre <= '0;
    else if (!enable || tick) pre <= '0;
    else                      pre <= pre + PRE_W'(1);
  end

`ifdef SENSOR_MASK_EN
  assign vote_vec = s & ~mask;
`else
  assign vote_vec = s;
`endif

  sensor_popcount7 u_popcount (
    .vec (vote_vec),
    .cnt (pc)
  );

  assign hit = (pc >= THR_L);

  // count/f keep sampling in every state, including ALARM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      f     <= 1'b1;
    end else if (tick) begin
      count <= pc;
      f     <= !hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alarm       <= 1'b0;
      run         <= '0;
      hold_cnt    <= '0;
      alarm_total <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      alarm    <= 1'b0;
      run      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= MONITOR;
        MONITOR: begin
          if (tick) begin
            if (hold_cnt != 8'd0) begin
              hold_cnt <= hold_cnt - 8'd1;
            end else if (hit) begin
              if (CONFIRM == 1) begin
                state       <= ALARM;
                alarm       <= 1'b1;
                alarm_total <= sat_inc8(alarm_total);
              end else begin
                state <= PENDING;
                run   <= 4'd1;
              end
            end
          end
        end
        PENDING: begin
          if (tick) begin
            if (!hit) begin
              state <= MONITOR;
              run   <= '0;
            end else if (run + 4'd1 == CONFIRM_L) begin
              state       <= ALARM;
              run         <= '0;
              alarm       <= 1'b1;
              alarm_total <= sat_inc8(alarm_total);
            end else begin
              run <= run + 4'd1;
            end
          end
        end
        ALARM: begin
          if (ack) begin
            state    <= MONITOR;
            alarm    <= 1'b0;
            hold_cnt <= HOLDOFF_L;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_sensor_vote_controller.sv
// Randomized bench for sensor_vote_controller against a behavioural reference model.
module tb_sensor_vote_controller;
  localparam int P_DIV  [2] = '{4, 1};
  localparam int P_THR  [2] = '{6, 6};
  localparam int P_CONF [2] = '{3, 1};
  localparam int P_HOLD [2] = '{8, 0};

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       en0 = 1'b0, ack0 = 1'b0, en1 = 1'b0, ack1 = 1'b0;
  logic [6:0] sin0 = '0, sin1 = '0, mask0 = '0, mask1 = '0;
  logic       f0, alarm0, f1, alarm1;
  logic [2:0] count0, count1;
  logic [1:0] st0, st1;
  logic [7:0] tot0, tot1;

  int n_checks = 0, n_errors = 0;
  bit run1 = 1'b0;

  // reference model state (per instance)
  bit [6:0] m_s1 [2], m_s2 [2];
  int       m_pre [2], m_run [2], m_hold [2], m_total [2], m_count [2];
  bit       m_idle [2], m_alarm [2], m_f [2];

  always #5 clk = ~clk;

  sensor_vote_controller #(.SAMPLE_DIV(4), .THRESHOLD(6), .CONFIRM(3), .HOLDOFF(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .sensor_in(sin0), .ack(ack0),
`ifdef SENSOR_MASK_EN
    .mask(mask0),
`endif
    .f(f0), .alarm(alarm0), .count(count0), .state_o(st0), .alarm_total(tot0)
  );

  sensor_vote_controller #(.SAMPLE_DIV(1), .THRESHOLD(6), .CONFIRM(1), .HOLDOFF(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .sensor_in(sin1), .ack(ack1),
`ifdef SENSOR_MASK_EN
    .mask(mask1),
`endif
    .f(f1), .alarm(alarm1), .count(count1), .state_o(st1), .alarm_total(tot1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int popc(input bit [6:0] v, input bit [6:0] m);
    int n = 0;
    for (int i = 0; i < 7; i++) if (v[i] && !m[i]) n++;
    return n;
  endfunction

  function automatic int m_state(input int k);
    if (m_idle[k])  return 0;
    if (m_alarm[k]) return 3;
    return (m_run[k] > 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_pre[k] = 0; m_run[k] = 0; m_hold[k] = 0;
      m_total[k] = 0; m_count[k] = 0; m_idle[k] = 1'b1; m_alarm[k] = 1'b0; m_f[k] = 1'b1;
    end
  endtask

  // one clock edge: inputs are those presented just before the edge
  task automatic model_step(input int k, input bit en, input bit [6:0] sin, input bit ackv,
                            input bit [6:0] mk);
    int  pc;
    bit  tick, hitv;
    pc   = popc(m_s2[k], mk);
    hitv = (pc >= P_THR[k]);
    tick = en && (m_pre[k] == P_DIV[k] - 1);
    m_s2[k]  = m_s1[k];
    m_s1[k]  = sin;
    m_pre[k] = (!en || tick) ? 0 : m_pre[k] + 1;
    if (tick) begin
      m_count[k] = pc;
      m_f[k]     = !hitv;
    end
    if (!en) begin
      m_idle[k] = 1'b1; m_alarm[k] = 1'b0; m_run[k] = 0; m_hold[k] = 0;
    end else if (m_idle[k]) begin
      m_idle[k] = 1'b0;
    end else if (m_alarm[k]) begin
      if (ackv) begin
        m_alarm[k] = 1'b0;
        m_hold[k]  = P_HOLD[k];
      end
    end else if (tick) begin
      if (m_hold[k] > 0) m_hold[k]--;
      else if (hitv) begin
        m_run[k]++;
        if (m_run[k] >= P_CONF[k]) begin
          m_alarm[k] = 1'b1;
          m_run[k]   = 0;
          if (m_total[k] < 255) m_total[k]++;
        end
      end else m_run[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0, en0, sin0, ack0, mask0);
      model_step(1, en1, sin1, ack1, mask1);
      #1;
      chk("state0", st0, m_state(0));   chk("alarm0", alarm0, m_alarm[0]);
      chk("count0", count0, m_count[0]); chk("f0", f0, m_f[0]);
      chk("total0", tot0, m_total[0]);
      chk("state1", st1, m_state(1));   chk("alarm1", alarm1, m_alarm[1]);
      chk("count1", count1, m_count[1]); chk("f1", f1, m_f[1]);
      chk("total1", tot1, m_total[1]);
    end
  end

  // background stimulus for the saturation instance
  always @(negedge clk) begin
    if (run1) begin
      en1  = 1'b1;
      sin1 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
      ack1 = $urandom_range(0, 1) == 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  off_cnt;
    bit  found;
    int  saved;
    model_reset();
    rst_n = 1'b0;
    step(3);
    chk("rst_state", st0, 0); chk("rst_alarm", alarm0, 0); chk("rst_f", f0, 1);
    chk("rst_count", count0, 0); chk("rst_total", tot0, 0);
    rst_n = 1'b1;
    run1  = 1'b1;

    // all sensors high: confirmed alarm
    en0 = 1'b1; sin0 = 7'h7F;
    step(30);
    chk("p1_alarm", alarm0, 1); chk("p1_total", tot0, 1);
    chk("p1_count", count0, 7); chk("p1_f", f0, 0);

    // ack with sensors still high: hold-off, then re-alarm
    ack0 = 1'b1; step(1); ack0 = 1'b0;
    chk("p2_ack_clr", alarm0, 0);
    step(30);
    chk("p2_holdoff", alarm0, 0);
    step(20);
    chk("p2_realarm", alarm0, 1); chk("p2_total", tot0, 2);

    // two hits then a miss: back to monitor without alarm
    ack0 = 1'b1; sin0 = 7'h1F; step(1); ack0 = 1'b0;
    step(60);
    sin0 = 7'h3F; step(8);
    sin0 = 7'h1F; step(12);
    chk("p3_alarm", alarm0, 0); chk("p3_state", st0, 1);
    chk("p3_count", count0, 5); chk("p3_f", f0, 1);

    // enable drops on the confirming tick
    sin0 = 7'h7F; found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (!m_alarm[0] && m_run[0] == P_CONF[0] - 1 && m_pre[0] == P_DIV[0] - 1 &&
          popc(m_s2[0], mask0) >= P_THR[0]) begin
        found = 1'b1;
        saved = m_total[0];
        en0   = 1'b0;
        step(1);
        chk("p4_state", st0, 0); chk("p4_alarm", alarm0, 0); chk("p4_total", tot0, saved);
        en0 = 1'b1;
      end else begin
        ack0 = m_alarm[0];
        step(1);
        ack0 = 1'b0;
      end
    end
    if (!found) chk("p4_timeout", 0, 1);

    // randomized traffic
    off_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      en0 = (off_cnt == 0);
      if (off_cnt > 0) off_cnt--;
      else if ($urandom_range(0, 99) == 0) off_cnt = $urandom_range(1, 5);
      case ($urandom_range(0, 4))
        0, 3:    sin0 = 7'h7F;
        1:       sin0 = 7'h3F;
        2:       sin0 = 7'h1F;
        default: sin0 = 7'($urandom);
      endcase
      ack0 = ($urandom_range(0, 7) == 0);
`ifdef SENSOR_MASK_EN
      if ($urandom_range(0, 49) == 0) mask0 = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'h00;
`endif
      step(1);
    end
    ack0 = 1'b0; en0 = 1'b1;

    chk("sat_total", tot1, 255);
    run1 = 1'b0; ack1 = 1'b0;

    // asynchronous reset while alarmed
    sin0 = 7'h7F; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      found = m_alarm[0];
    end
    if (!found) chk("p7_timeout", 0, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("p7_alarm", alarm0, 0); chk("p7_state", st0, 0); chk("p7_total", tot0, 0);
    chk("p7_count", count0, 0); chk("p7_f", f0, 1);
    step(1);
    rst_n = 1'b1;
    step(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
